i2c_slave_regfile: RTL and testbench

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_slave_pkg.sv | 29 ++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_slave_regfile.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave register file.
package i2c_slave_pkg;

  // Protocol phases of the slave. Each *_ACK state covers the ninth SCL
  // period of a byte.
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  // Bit counter value when the last (8th) data bit is being sampled
  localparam logic [3:0] BIT_CNT_LAST = 4'd7;
  // Bit counter value once all 8 bits of a transmitted byte have been clocked out
  localparam logic [3:0] BIT_CNT_DONE = 4'd8;

  // SDA level that signals acknowledge
  localparam logic ACK_LEVEL   = 1'b0;
  // Output-enable levels (open drain: 0 pulls low, 1 releases)
  localparam logic SDA_PULL    = 1'b0;
  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and derives SCL edges plus START/STOP events.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync_reg;
  logic [1:0] sda_sync_reg;
  logic       scl_prev_reg;
  logic       sda_prev_reg;
  logic       scl;

  // Two-flop synchronisers followed by one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl_pad_i};
      sda_sync_reg <= {sda_sync_reg[0], sda_pad_i};
      scl_prev_reg <= scl_sync_reg[1];
      sda_prev_reg <= sda_sync_reg[1];
    end
  end

  assign scl      = scl_sync_reg[1];
  assign sda      = sda_sync_reg[1];
  assign scl_rise = scl & ~scl_prev_reg;
  assign scl_fall = ~scl & scl_prev_reg;
  // SDA edges only count as bus conditions while SCL was high on both samples
  assign start    = scl & scl_prev_reg & sda_prev_reg & ~sda;
  assign stop     = scl & scl_prev_reg & ~sda_prev_reg & sda;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS byte registers with an auto-incrementing pointer.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDRESS  = 7'h50,
  parameter int         NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_pad_i,
  output logic                        scl_pad_o,
  output logic                        scl_padoen_o,
  input  logic                        sda_pad_i,
  output logic                        sda_pad_o,
  output logic                        sda_padoen_o,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_i,
  output logic [7:0]                  rd_data_o,
  output logic                        wr_valid_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
  output logic [7:0]                  wr_data_o,
  output logic                        busy_o
);

  localparam int AW = $clog2(NUM_REGS);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  state_t        state_reg, state_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [6:0]    shift_reg, shift_next;
  logic [6:0]    tx_reg, tx_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic          rw_reg, rw_next;
  logic          ack_phase_reg, ack_phase_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          busy_reg, busy_next;
  logic          wr_valid_reg, wr_valid_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;

  logic [7:0]    regs [NUM_REGS];
  logic [7:0]    byte_in;
  logic [7:0]    cur_byte;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_pad_i (scl_pad_i),
    .sda_pad_i (sda_pad_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start     (start),
    .stop      (stop)
  );

  // Byte completed by the current SCL rise, and the register the pointer selects
  assign byte_in  = {shift_reg, sda};
  assign cur_byte = regs[ptr_reg];

  // Register storage: written one cycle after the wr_valid pulse is raised
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // One storage byte, cleared by reset, loaded on a matching I2C write
      always_ff @(posedge clk) begin
        if (rst) begin
          regs[gi] <= 8'h00;
        end else if (wr_valid_reg && (wr_addr_reg == AW'(gi))) begin
          regs[gi] <= wr_data_reg;
        end
      end
    end
  endgenerate

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      ack_phase_reg <= 1'b0;
      sda_oe_reg    <= SDA_RELEASE;
      busy_reg      <= 1'b0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      ptr_reg       <= ptr_next;
      rw_reg        <= rw_next;
      ack_phase_reg <= ack_phase_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      wr_valid_reg  <= wr_valid_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // Protocol FSM: bus conditions first, then per-state bit handling.
  // SDA is sampled on SCL rise; the drive level changes only on SCL fall.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    tx_next        = tx_reg;
    ptr_next       = ptr_reg;
    rw_next        = rw_reg;
    ack_phase_next = ack_phase_reg;
    sda_oe_next    = sda_oe_reg;
    busy_next      = busy_reg;
    wr_valid_next  = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;

    if (start) begin
      // START or repeated START: busy and pointer carry over to the new address phase
      state_next     = ADDR;
      bit_cnt_next   = '0;
      ack_phase_next = 1'b0;
      sda_oe_next    = SDA_RELEASE;
    end else if (stop) begin
      // STOP abandons any partial byte; pointer is kept
      state_next  = IDLE;
      sda_oe_next = SDA_RELEASE;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_next   = byte_in[6:0];
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == BIT_CNT_LAST) begin
              bit_cnt_next   = '0;
              ack_phase_next = 1'b0;
              if (state_reg == ADDR) begin
                if (byte_in[7:1] == ADDRESS) begin
                  state_next = ADDR_ACK;
                  rw_next    = byte_in[0];
                  busy_next  = 1'b1;
                end else begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
                end
              end else if (state_reg == PTR) begin
                ptr_next   = byte_in[AW-1:0];
                state_next = PTR_ACK;
              end else begin
                wr_valid_next = 1'b1;
                wr_addr_next  = ptr_reg;
                wr_data_next  = byte_in;
                ptr_next      = ptr_reg + AW'(1);
                state_next    = WDATA_ACK;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First fall (end of bit 8) pulls SDA, second fall (end of ACK) moves on
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              sda_oe_next    = SDA_PULL;
              ack_phase_next = 1'b1;
            end else begin
              ack_phase_next = 1'b0;
              bit_cnt_next   = '0;
              if ((state_reg == ADDR_ACK) && rw_reg) begin
                state_next  = RDATA;
                sda_oe_next = cur_byte[7];
                tx_next     = cur_byte[6:0];
              end else begin
                sda_oe_next = SDA_RELEASE;
                state_next  = (state_reg == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == BIT_CNT_DONE) begin
              // Byte fully clocked out: let the master drive its ACK bit
              sda_oe_next    = SDA_RELEASE;
              ack_phase_next = 1'b0;
              bit_cnt_next   = '0;
              state_next     = RDATA_ACK;
            end else begin
              sda_oe_next = tx_reg[6];
              tx_next     = {tx_reg[5:0], 1'b0};
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == ACK_LEVEL) begin
              ack_phase_next = 1'b1;
              ptr_next       = ptr_reg + AW'(1);
            end else begin
              state_next  = IDLE;
              sda_oe_next = SDA_RELEASE;
              busy_next   = 1'b0;
            end
          end else if (scl_fall && ack_phase_reg) begin
            // Pointer already advanced on the ACK rise; start the next byte
            state_next     = RDATA;
            ack_phase_next = 1'b0;
            bit_cnt_next   = '0;
            sda_oe_next    = cur_byte[7];
            tx_next        = cur_byte[6:0];
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oe_reg;
  assign busy_o       = busy_reg;
  assign wr_valid_o   = wr_valid_reg;
  assign wr_addr_o    = wr_addr_reg;
  assign wr_data_o    = wr_data_reg;
  assign rd_data_o    = regs[rd_addr_i];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, table vectors,
// directed corner cases and random transactions against a register model.
module tb_i2c_slave_regfile;

  localparam logic [6:0] DEV  = 7'h50;
  localparam int         NREG = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       scl_bus;
  logic       sda_bus;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents and pointer
  logic [7:0]  m_regs [NREG];
  int          m_ptr;
  logic [11:0] exp_q [$];
  logic [11:0] got_q [$];
  int          busy_cnt = 0;

  logic [7:0] tx_buf [5];
  logic [7:0] rx_buf [5];

  typedef struct {
    logic [6:0] dev;
    int         n;
    logic [7:0] b0, b1, b2;
    logic [3:0] ca0;
    logic [7:0] cv0;
    logic [3:0] ca1;
    logic [7:0] cv1;
    int         pulses;
  } vec_t;
  vec_t vecs [4];

  // Open-drain wired-AND bus
  assign scl_bus = scl & (scl_padoen_o | scl_pad_o);
  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  always #5 clk = ~clk;

  i2c_slave_regfile #(.ADDRESS(DEV), .NUM_REGS(NREG)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_pad_i    (scl_bus),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .wr_valid_o   (wr_valid),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy)
  );

  // Monitor: record write pulses and busy cycles away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) got_q.push_back({wr_addr, wr_data});
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] v);
    rd_addr = a;
    #1;
    check($sformatf("reg[%0d]", a), rd_data, v);
  endtask

  task automatic check_pulses(input int base);
    int got_n;
    got_n = got_q.size() - base;
    check("pulse_count", got_n, exp_q.size());
    for (int i = 0; i < got_n && i < exp_q.size(); i++)
      check("pulse_addr_data", got_q[base + i], exp_q[i]);
  endtask

  task automatic run_write(input logic [6:0] dev, input int n);
    logic ack, hit;
    int   base, bbase;
    hit = (dev == DEV);
    base = got_q.size(); bbase = busy_cnt; exp_q.delete();
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    check("w_addr_ack", ack, hit ? 1'b0 : 1'b1);
    if (hit) begin
      for (int i = 0; i < n; i++) begin
        write_byte(tx_buf[i], ack);
        check("w_data_ack", ack, 1'b0);
      end
    end
    i2c_stop(); wait_q();
    if (hit) begin
      m_ptr = tx_buf[0] % NREG;
      for (int i = 1; i < n; i++) begin
        exp_q.push_back({4'(m_ptr), tx_buf[i]});
        m_regs[m_ptr] = tx_buf[i];
        m_ptr = (m_ptr + 1) % NREG;
      end
    end
    check_pulses(base);
    check("w_busy_seen", busy_cnt != bbase, hit);
    check("w_busy_end", busy, 1'b0);
    $display("txn write dev=0x%02h bytes=%0d hit=%0d", dev, n, hit);
  endtask

  task automatic do_reads(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      read_byte(d, i == n - 1);
      rx_buf[i] = d;
      check("r_data", d, m_regs[m_ptr]);
      if (i != n - 1) m_ptr = (m_ptr + 1) % NREG;
    end
    check("r_sda_released", sda_padoen_o, 1'b1);
  endtask

  task automatic run_read(input logic [6:0] dev, input int n);
    logic ack, hit;
    int   base;
    hit = (dev == DEV);
    base = got_q.size(); exp_q.delete();
    i2c_start();
    write_byte({dev, 1'b1}, ack);
    check("r_addr_ack", ack, hit ? 1'b0 : 1'b1);
    if (hit) do_reads(n);
    i2c_stop(); wait_q();
    check_pulses(base);
    check("r_busy_end", busy, 1'b0);
    $display("txn read dev=0x%02h bytes=%0d hit=%0d", dev, n, hit);
  endtask

  task automatic run_ptr_read(input logic [7:0] p, input int n);
    logic ack;
    int   base;
    base = got_q.size(); exp_q.delete();
    i2c_start();
    write_byte({DEV, 1'b0}, ack); check("pr_addr_ack", ack, 1'b0);
    write_byte(p, ack);           check("pr_ptr_ack", ack, 1'b0);
    i2c_rstart();
    write_byte({DEV, 1'b1}, ack); check("pr_raddr_ack", ack, 1'b0);
    check("pr_busy_mid", busy, 1'b1);
    m_ptr = p % NREG;
    do_reads(n);
    i2c_stop(); wait_q();
    check_pulses(base);
    check("pr_busy_end", busy, 1'b0);
    $display("txn ptr_read ptr=0x%02h bytes=%0d", p, n);
  endtask

  initial begin
    logic       ack;
    logic [6:0] dev;
    int         kind, n, base;

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_addr = '0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_padoen", sda_padoen_o, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("scl_pad_o", scl_pad_o, 1'b0);
    check("scl_padoen_o", scl_padoen_o, 1'b1);
    check("sda_pad_o", sda_pad_o, 1'b0);
    rst = 1'b0;
    wait_q();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 8'h00;
      check_reg(4'(i), 8'h00);
    end
    m_ptr = 0;
    $display("txn reset done");

    // Table-driven write vectors with hand-computed register expectations
    vecs[0] = '{7'h50, 3, 8'h03, 8'h5A, 8'hC3, 4'd3,  8'h5A, 4'd4, 8'hC3, 2};
    vecs[1] = '{7'h51, 2, 8'h04, 8'hFF, 8'h00, 4'd4,  8'hC3, 4'd3, 8'h5A, 0};
    vecs[2] = '{7'h50, 3, 8'h0F, 8'h11, 8'h22, 4'd15, 8'h11, 4'd0, 8'h22, 2};
    vecs[3] = '{7'h50, 2, 8'h17, 8'h66, 8'h00, 4'd7,  8'h66, 4'd15, 8'h11, 1};
    for (int v = 0; v < 4; v++) begin
      tx_buf[0] = vecs[v].b0; tx_buf[1] = vecs[v].b1; tx_buf[2] = vecs[v].b2;
      base = got_q.size();
      run_write(vecs[v].dev, vecs[v].n);
      check("vec_pulses", got_q.size() - base, vecs[v].pulses);
      check_reg(vecs[v].ca0, vecs[v].cv0);
      check_reg(vecs[v].ca1, vecs[v].cv1);
    end

    // Write pointer, repeated START, read two bytes
    run_ptr_read(8'h03, 2);
    check("sr_read_b0", rx_buf[0], 8'h5A);
    check("sr_read_b1", rx_buf[1], 8'hC3);

    // STOP four bits into a data byte: nothing written, pointer kept
    base = got_q.size();
    i2c_start();
    write_byte({DEV, 1'b0}, ack); check("ab_addr_ack", ack, 1'b0);
    write_byte(8'h04, ack);       check("ab_ptr_ack", ack, 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop(); wait_q();
    check("ab_pulses", got_q.size() - base, 0);
    check("ab_busy", busy, 1'b0);
    check("ab_sda_released", sda_padoen_o, 1'b1);
    check_reg(4'd4, 8'hC3);
    m_ptr = 4;
    $display("txn abort mid-byte");
    run_read(DEV, 1);
    check("ab_ptr_kept", rx_buf[0], 8'hC3);
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h77;
    run_write(DEV, 2);
    check_reg(4'd5, 8'h77);

    // Randomised transactions against the model
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      dev  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      n    = $urandom_range(1, 4);
      for (int i = 0; i < 5; i++) tx_buf[i] = 8'($urandom);
      case (kind)
        0:       run_write(dev, n);
        1:       run_read(dev, n);
        default: run_ptr_read(8'($urandom), n);
      endcase
    end
    for (int i = 0; i < NREG; i++) check_reg(4'(i), m_regs[i]);

    // Reset while the slave drives a 0 data bit
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h5A;
    run_write(DEV, 2);
    i2c_start();
    write_byte({DEV, 1'b0}, ack); check("rr_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack);       check("rr_ptr_ack", ack, 1'b0);
    i2c_rstart();
    write_byte({DEV, 1'b1}, ack); check("rr_raddr_ack", ack, 1'b0);
    check("rr_driving_zero", sda_padoen_o, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rr_sda_released", sda_padoen_o, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_q();
    i2c_stop(); wait_q();
    check("rr_busy", busy, 1'b0);
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 8'h00;
      check_reg(4'(i), 8'h00);
    end
    m_ptr = 0;
    $display("txn reset mid-read");

    // Bus works normally after the reset
    tx_buf[0] = 8'h02; tx_buf[1] = 8'hAB;
    run_write(DEV, 2);
    run_ptr_read(8'h02, 1);
    check("post_rst_read", rx_buf[0], 8'hAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
